// File: rtl/cifra_cesar_buffer.sv
// Caesar-cipher message buffer.
// Collects up to MSG_LEN letter codes, one per press of the entry button.
// On the start button it plays the stored word back one ciphered letter at a
// time, holding each letter on saida for SCROLL_DIV clock cycles.
module cifra_cesar_buffer #(
  parameter int MSG_LEN    = 8,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [4:0]                     entrada,
  input  logic                           pronto,
  input  logic [4:0]                     chave,
  input  logic                           modo,
  input  logic                           iniciar,
  output logic [4:0]                     saida,
  output logic                           saida_valid,
  output logic                           ocupado,
  output logic                           cheio,
  output logic [$clog2(MSG_LEN+1)-1:0]   contagem
);

  localparam int CW = $clog2(MSG_LEN + 1);
  localparam int IW = $clog2(MSG_LEN);
  localparam int TW = $clog2(SCROLL_DIV);

  localparam logic [4:0]    BLANK      = 5'd31;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCROLL_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(MSG_LEN);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Key reduction: any 5-bit key folds into 0..25 (26 -> 0, 31 -> 5).
  function automatic logic [4:0] reduce_key(input logic [4:0] c);
    logic [4:0] r;
    if (c >= 5'd26) begin
      r = c - 5'd26;
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Shift a letter by k (forward to encrypt, backward to decrypt).
  // Non-letter codes 26..31 pass through untouched; a single conditional
  // subtract of 26 suffices because the 6-bit sum never reaches 52.
  function automatic logic [4:0] cipher(input logic [4:0] x,
                                        input logic [4:0] k,
                                        input logic       dec);
    logic [5:0] s;
    logic [4:0] r;
    if (x >= 5'd26) begin
      r = x;
    end else begin
      if (dec) begin
        s = {1'b0, x} + 6'd26 - {1'b0, k};
      end else begin
        s = {1'b0, x} + {1'b0, k};
      end
      if (s >= 6'd26) begin
        s = s - 6'd26;
      end else begin
        s = s;
      end
      r = s[4:0];
    end
    return r;
  endfunction

  state_t          state_r;
  logic [4:0]      mem_r [MSG_LEN];
  logic [CW-1:0]   contagem_r;
  logic            cheio_r;
  logic            ocupado_r;
  logic [4:0]      saida_r;
  logic            saida_valid_r;
  logic [IW-1:0]   idx_r;
  logic [TW-1:0]   timer_r;
  logic [4:0]      key_r;
  logic            modo_r;

  logic            pronto_meta_r, pronto_sync_r, pronto_hist_r;
  logic            iniciar_meta_r, iniciar_sync_r, iniciar_hist_r;

  logic            pronto_edge_s;
  logic            iniciar_edge_s;
  logic            store_s;
  logic            start_s;
  logic [CW-1:0]   count_next_s;
  logic [IW-1:0]   wr_idx_s;
  logic [IW-1:0]   idx_next_s;
  logic [CW-1:0]   idx_next_wide_s;
  logic            more_s;
  logic [4:0]      key_in_s;
  logic [4:0]      first_s;

  // Two-flop synchronizers plus a history flop for both asynchronous buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pronto_meta_r  <= 1'b0;
      pronto_sync_r  <= 1'b0;
      pronto_hist_r  <= 1'b0;
      iniciar_meta_r <= 1'b0;
      iniciar_sync_r <= 1'b0;
      iniciar_hist_r <= 1'b0;
    end else begin
      pronto_meta_r  <= pronto;
      pronto_sync_r  <= pronto_meta_r;
      pronto_hist_r  <= pronto_sync_r;
      iniciar_meta_r <= iniciar;
      iniciar_sync_r <= iniciar_meta_r;
      iniciar_hist_r <= iniciar_sync_r;
    end
  end

  // Edge detection, store/start decisions and playback index arithmetic.
  always_comb begin
    pronto_edge_s   = pronto_sync_r & ~pronto_hist_r;
    iniciar_edge_s  = iniciar_sync_r & ~iniciar_hist_r;
    store_s         = (state_r == IDLE) && pronto_edge_s && !cheio_r;
    count_next_s    = contagem_r + CW'(store_s);
    start_s         = (state_r == IDLE) && iniciar_edge_s && (count_next_s != '0);
    wr_idx_s        = contagem_r[IW-1:0];
    idx_next_s      = idx_r + IW'(1);
    idx_next_wide_s = CW'(idx_r) + CW'(1);
    more_s          = (idx_next_wide_s < contagem_r);
    key_in_s        = reduce_key(chave);
    // A letter stored on the same cycle as the start lands in slot 0 only
    // when the buffer was empty, so it must bypass the memory read.
    if (contagem_r == '0) begin
      first_s = entrada;
    end else begin
      first_s = mem_r[0];
    end
  end

  // Message storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_idx_s] <= entrada;
    end
  end

  // Main control: capture in IDLE, timed ciphered playback in SHOW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      contagem_r    <= '0;
      cheio_r       <= 1'b0;
      ocupado_r     <= 1'b0;
      saida_r       <= BLANK;
      saida_valid_r <= 1'b0;
      idx_r         <= '0;
      timer_r       <= '0;
      key_r         <= 5'd0;
      modo_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (store_s) begin
            contagem_r <= count_next_s;
            cheio_r    <= (count_next_s == FULL_COUNT);
          end
          if (start_s) begin
            state_r       <= SHOW;
            ocupado_r     <= 1'b1;
            key_r         <= key_in_s;
            modo_r        <= modo;
            idx_r         <= '0;
            timer_r       <= '0;
            saida_r       <= cipher(first_s, key_in_s, modo);
            saida_valid_r <= 1'b1;
          end else if (store_s) begin
            saida_r <= entrada;
          end
        end
        SHOW: begin
          if (timer_r == TIMER_LAST) begin
            timer_r <= '0;
            if (more_s) begin
              idx_r   <= idx_next_s;
              saida_r <= cipher(mem_r[idx_next_s], key_r, modo_r);
            end else begin
              state_r       <= IDLE;
              ocupado_r     <= 1'b0;
              contagem_r    <= '0;
              cheio_r       <= 1'b0;
              saida_r       <= BLANK;
              saida_valid_r <= 1'b0;
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r       <= IDLE;
          ocupado_r     <= 1'b0;
          contagem_r    <= '0;
          cheio_r       <= 1'b0;
          saida_r       <= BLANK;
          saida_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign saida       = saida_r;
  assign saida_valid = saida_valid_r;
  assign ocupado     = ocupado_r;
  assign cheio       = cheio_r;
  assign contagem    = contagem_r;

endmodule
